// File: rtl/ibex_rf_ctx_pkg.sv
// Shared types and address-range helpers for the register-file context engine.
package ibex_rf_ctx_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SAVE,
    ST_SAVE_DRAIN,
    ST_RESTORE,
    ST_RESTORE_WB,
    ST_FINISH
  } ctx_state_e;

  typedef logic [4:0] reg_addr_t;

  function automatic int unsigned addr_w(input bit rv32e);
    return rv32e ? 32'd4 : 32'd5;
  endfunction

  function automatic reg_addr_t first_addr(input bit skip_r0);
    return skip_r0 ? 5'd1 : 5'd0;
  endfunction

  function automatic reg_addr_t last_addr(input bit rv32e);
    return reg_addr_t'((32'd1 << addr_w(rv32e)) - 32'd1);
  endfunction

endpackage

// File: rtl/ibex_rf_ctx_if.sv
// Register-file port plus save/restore stream bundle; master = engine, slave = RF/stream side.
interface ibex_rf_ctx_if #(
  parameter int unsigned DataWidth = 32
) ();

  logic [4:0]           rf_raddr_o;
  logic [DataWidth-1:0] rf_rdata_i;
  logic [4:0]           rf_waddr_o;
  logic [DataWidth-1:0] rf_wdata_o;
  logic                 rf_we_o;

  logic                 sv_valid_o;
  logic                 sv_ready_i;
  logic [4:0]           sv_addr_o;
  logic [DataWidth-1:0] sv_data_o;

  logic                 rs_valid_i;
  logic                 rs_ready_o;
  logic [DataWidth-1:0] rs_data_i;

  modport master (
    output rf_raddr_o, rf_waddr_o, rf_wdata_o, rf_we_o,
    input  rf_rdata_i,
    output sv_valid_o, sv_addr_o, sv_data_o,
    input  sv_ready_i,
    input  rs_valid_i, rs_data_i,
    output rs_ready_o
  );

  modport slave (
    input  rf_raddr_o, rf_waddr_o, rf_wdata_o, rf_we_o,
    output rf_rdata_i,
    input  sv_valid_o, sv_addr_o, sv_data_o,
    output sv_ready_i,
    output rs_valid_i, rs_data_i,
    input  rs_ready_o
  );

endinterface

// File: rtl/ibex_rf_ctx_csum.sv
// Wrapping word accumulator: clear has priority over enable, result registered.
module ibex_rf_ctx_csum #(
  parameter int unsigned DataWidth = 32
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 clr_i,
  input  logic                 en_i,
  input  logic [DataWidth-1:0] data_i,
  output logic [DataWidth-1:0] sum_o
);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sum_o <= '0;
    end else if (clr_i) begin
      sum_o <= '0;
    end else if (en_i) begin
      sum_o <= sum_o + data_i;
    end
  end

endmodule

// File: rtl/ibex_rf_ctx_engine.sv
// Saves the RF to an outbound stream (1 word/cycle, stalls on sv_ready_i) or restores it (1-cycle write latency).
// Optional transfer checksum under IBEX_RF_CTX_CHECKSUM_EN; otherwise csum_o is tied to 0.
module ibex_rf_ctx_engine
  import ibex_rf_ctx_pkg::*;
#(
  parameter bit          RV32E     = 1'b0,
  parameter int unsigned DataWidth = 32,
  parameter bit          SkipR0    = 1'b1
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 save_req_i,
  input  logic                 restore_req_i,
  input  logic                 abort_i,
  output logic                 busy_o,
  output logic                 done_o,
  output logic                 aborted_o,
  ibex_rf_ctx_if.master        bus,
  output logic [DataWidth-1:0] csum_o
);

  localparam reg_addr_t FIRST = first_addr(SkipR0);
  localparam reg_addr_t LAST  = last_addr(RV32E);

  ctx_state_e           state_q;
  reg_addr_t            cnt_q;
  logic                 sv_valid_q;
  reg_addr_t            sv_addr_q;
  logic [DataWidth-1:0] sv_data_q;
  logic                 rf_we_q;
  reg_addr_t            rf_waddr_q;
  logic [DataWidth-1:0] rf_wdata_q;
  logic                 done_q;
  logic                 aborted_q;

  logic out_free;
  logic sv_hs;

  assign out_free = !sv_valid_q || bus.sv_ready_i;
  assign sv_hs    = sv_valid_q && bus.sv_ready_i;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      sv_valid_q <= 1'b0;
      sv_addr_q  <= '0;
      sv_data_q  <= '0;
      rf_we_q    <= 1'b0;
      rf_waddr_q <= '0;
      rf_wdata_q <= '0;
      done_q     <= 1'b0;
      aborted_q  <= 1'b0;
    end else begin
      done_q    <= 1'b0;
      aborted_q <= 1'b0;
      rf_we_q   <= 1'b0;
      // Abort overrides everything, including a final handshake in the same cycle.
      if (abort_i && state_q != ST_IDLE) begin
        state_q    <= ST_IDLE;
        aborted_q  <= 1'b1;
        sv_valid_q <= 1'b0;
      end else begin
        case (state_q)
          ST_IDLE: begin
            if (save_req_i) begin
              state_q <= ST_SAVE;
              cnt_q   <= FIRST;
            end else if (restore_req_i) begin
              state_q <= ST_RESTORE;
              cnt_q   <= FIRST;
            end
          end
          ST_SAVE: begin
            if (out_free) begin
              sv_data_q  <= bus.rf_rdata_i;
              sv_addr_q  <= cnt_q;
              sv_valid_q <= 1'b1;
              if (cnt_q == LAST) state_q <= ST_SAVE_DRAIN;
              else               cnt_q   <= cnt_q + 5'd1;
            end
          end
          ST_SAVE_DRAIN: begin
            if (sv_hs) begin
              sv_valid_q <= 1'b0;
              state_q    <= ST_FINISH;
              done_q     <= 1'b1;
            end
          end
          ST_RESTORE: begin
            if (bus.rs_valid_i) begin
              rf_we_q    <= 1'b1;
              rf_waddr_q <= cnt_q;
              rf_wdata_q <= bus.rs_data_i;
              if (cnt_q == LAST) state_q <= ST_RESTORE_WB;
              else               cnt_q   <= cnt_q + 5'd1;
            end
          end
          ST_RESTORE_WB: begin
            state_q <= ST_FINISH;
            done_q  <= 1'b1;
          end
          ST_FINISH: begin
            state_q <= ST_IDLE;
          end
          default: begin
            state_q <= ST_IDLE;
          end
        endcase
      end
    end
  end

  assign busy_o         = (state_q != ST_IDLE);
  assign done_o         = done_q;
  assign aborted_o      = aborted_q;
  assign bus.rf_raddr_o = cnt_q;
  assign bus.rf_we_o    = rf_we_q;
  assign bus.rf_waddr_o = rf_waddr_q;
  assign bus.rf_wdata_o = rf_wdata_q;
  assign bus.sv_valid_o = sv_valid_q;
  assign bus.sv_addr_o  = sv_addr_q;
  assign bus.sv_data_o  = sv_data_q;
  assign bus.rs_ready_o = (state_q == ST_RESTORE);

`ifdef IBEX_RF_CTX_CHECKSUM_EN
  logic                 rs_acc;
  logic                 csum_clr;
  logic                 csum_en;
  logic [DataWidth-1:0] csum_din;

  assign rs_acc   = (state_q == ST_RESTORE) && bus.rs_valid_i;
  assign csum_clr = (state_q == ST_IDLE) && (save_req_i || restore_req_i);
  assign csum_en  = !abort_i && (sv_hs || rs_acc);
  assign csum_din = rs_acc ? bus.rs_data_i : sv_data_q;

  ibex_rf_ctx_csum #(
    .DataWidth(DataWidth)
  ) u_csum (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .clr_i (csum_clr),
    .en_i  (csum_en),
    .data_i(csum_din),
    .sum_o (csum_o)
  );
`else
  assign csum_o = '0;
`endif

endmodule

// File: tb/tb_ibex_rf_ctx_engine.sv
// Scoreboard bench: instance A (RV32I, skip x0) for saves, instance B (RV32E, keep x0) for restores.
module tb_ibex_rf_ctx_engine;

  logic clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  logic        rst_i;
  logic        save_req_a, restore_req_a, abort_a, busy_a, done_a, aborted_a;
  logic        save_req_b, restore_req_b, abort_b, busy_b, done_b, aborted_b;
  logic [31:0] csum_a, csum_b;

  ibex_rf_ctx_if #(.DataWidth(32)) bus_a ();
  ibex_rf_ctx_if #(.DataWidth(32)) bus_b ();

  ibex_rf_ctx_engine #(.RV32E(1'b0), .DataWidth(32), .SkipR0(1'b1)) u_dut_a (
    .clk_i(clk_i), .rst_i(rst_i), .save_req_i(save_req_a), .restore_req_i(restore_req_a),
    .abort_i(abort_a), .busy_o(busy_a), .done_o(done_a), .aborted_o(aborted_a),
    .bus(bus_a.master), .csum_o(csum_a));

  ibex_rf_ctx_engine #(.RV32E(1'b1), .DataWidth(32), .SkipR0(1'b0)) u_dut_b (
    .clk_i(clk_i), .rst_i(rst_i), .save_req_i(save_req_b), .restore_req_i(restore_req_b),
    .abort_i(abort_b), .busy_o(busy_b), .done_o(done_b), .aborted_o(aborted_b),
    .bus(bus_b.master), .csum_o(csum_b));

  logic [31:0] rf_a [32];
  logic [31:0] rf_b [32];
  assign bus_a.rf_rdata_i = rf_a[bus_a.rf_raddr_o];
  assign bus_b.rf_rdata_i = rf_b[bus_b.rf_raddr_o];
  always @(posedge clk_i) if (bus_b.rf_we_o) rf_b[bus_b.rf_waddr_o] <= bus_b.rf_wdata_o;

  int cyc = 0;
  always @(posedge clk_i) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  typedef struct { logic [4:0] addr; logic [31:0] data; } beat_t;
  typedef struct { logic [4:0] addr; logic [31:0] data; int cyc; } wr_t;
  beat_t sv_q[$];
  wr_t   wr_q[$];
  beat_t sv_e;
  wr_t   wr_e;

  int sv_beats = 0, sv_beats0 = 0, last_hs_cyc = 0;
  int done_a_cnt = 0, done_a_cyc = 0, done_b_cnt = 0, done_b_cyc = 0;
  int wr_b_cnt = 0, last_we_b_cyc = 0, stray_a = 0;
  bit chk_consec = 1'b0;
  logic        prev_stall = 1'b0;
  logic [4:0]  prev_addr  = '0;
  logic [31:0] prev_data  = '0;

  always @(negedge clk_i) begin
    if (!rst_i) begin
      if (bus_a.sv_valid_o && prev_stall) begin
        chk("sv_hold_addr", bus_a.sv_addr_o, prev_addr);
        chk("sv_hold_data", bus_a.sv_data_o, prev_data);
      end
      if (bus_a.sv_valid_o && bus_a.sv_ready_i) begin
        if (sv_q.size() == 0) chk("sv_extra_beat", 1, 0);
        else begin
          sv_e = sv_q.pop_front();
          chk("sv_addr", bus_a.sv_addr_o, sv_e.addr);
          chk("sv_data", bus_a.sv_data_o, sv_e.data);
        end
        if (chk_consec && sv_beats > sv_beats0) chk("sv_consec", cyc - last_hs_cyc, 1);
        sv_beats++;
        last_hs_cyc = cyc;
      end
      prev_stall = bus_a.sv_valid_o && !bus_a.sv_ready_i;
      prev_addr  = bus_a.sv_addr_o;
      prev_data  = bus_a.sv_data_o;
      if (done_a) begin done_a_cnt++; done_a_cyc = cyc; end
      if (bus_a.rf_we_o || bus_a.rs_ready_o) stray_a++;
      if (bus_b.rf_we_o) begin
        if (wr_q.size() == 0) chk("wr_extra", 1, 0);
        else begin
          wr_e = wr_q.pop_front();
          chk("wr_addr", bus_b.rf_waddr_o, wr_e.addr);
          chk("wr_data", bus_b.rf_wdata_o, wr_e.data);
          chk("wr_cycle", cyc, wr_e.cyc);
        end
        wr_b_cnt++;
        last_we_b_cyc = cyc;
      end
      if (done_b) begin done_b_cnt++; done_b_cyc = cyc; end
    end
  end

  task automatic start_save(input bit both);
    for (int n = 1; n < 32; n++) begin
      sv_e.addr = 5'(n);
      sv_e.data = rf_a[n];
      sv_q.push_back(sv_e);
    end
    sv_beats0     = sv_beats;
    save_req_a    = 1'b1;
    restore_req_a = both;
    tick();
    save_req_a    = 1'b0;
    restore_req_a = 1'b0;
  endtask

  task automatic wait_done_a();
    int d0 = done_a_cnt;
    for (int i = 0; i < 400 && done_a_cnt == d0; i++) tick();
    tick();
    tick();
    chk("done_a_once", done_a_cnt - d0, 1);
  endtask

  task automatic restore_word(input int k, input logic [31:0] d);
    bus_b.rs_valid_i = 1'b1;
    bus_b.rs_data_i  = d;
    for (int t = 0; t < 20 && !bus_b.rs_ready_o; t++) tick();
    wr_e.addr = 5'(k);
    wr_e.data = d;
    wr_e.cyc  = cyc + 1;
    wr_q.push_back(wr_e);
    tick();
    bus_b.rs_valid_i = 1'b0;
  endtask

  initial begin
    automatic logic [3:0] pat = 4'b1001;
    int k, d0, w0;
    rst_i = 1'b1;
    save_req_a = 0; restore_req_a = 0; abort_a = 0;
    save_req_b = 0; restore_req_b = 0; abort_b = 0;
    bus_a.sv_ready_i = 1'b1; bus_a.rs_valid_i = 1'b0; bus_a.rs_data_i = '0;
    bus_b.sv_ready_i = 1'b0; bus_b.rs_valid_i = 1'b0; bus_b.rs_data_i = '0;
    for (int n = 0; n < 32; n++) begin rf_a[n] = 32'h100 + n; rf_b[n] = 32'hDEAD0000; end
    tick(); tick(); tick();
    chk("rst_busy_a", busy_a, 0);
    chk("rst_done_a", done_a, 0);
    chk("rst_sv_valid_a", bus_a.sv_valid_o, 0);
    chk("rst_rs_ready_b", bus_b.rs_ready_o, 0);
    chk("rst_we_b", bus_b.rf_we_o, 0);
    chk("rst_csum_a", csum_a, 0);
    rst_i = 1'b0;
    tick();

    // Save with ready tied high.
    chk_consec = 1'b1;
    start_save(1'b0);
    wait_done_a();
    chk("t1_beats", sv_beats - sv_beats0, 31);
    chk("t1_q_empty", sv_q.size(), 0);
    chk("t1_done_lat", done_a_cyc - last_hs_cyc, 1);
    chk("t1_busy_after", busy_a, 0);

    // Save with ready pattern 1,0,0,1.
    for (int n = 0; n < 32; n++) rf_a[n] = 32'h5000 + 3 * n;
    chk_consec = 1'b0;
    start_save(1'b0);
    d0 = done_a_cnt;
    k = 0;
    while (done_a_cnt == d0 && k < 400) begin
      bus_a.sv_ready_i = pat[k % 4];
      tick();
      k++;
    end
    bus_a.sv_ready_i = 1'b1;
    chk("t2_done", done_a_cnt - d0, 1);
    chk("t2_beats", sv_beats - sv_beats0, 31);
    chk("t2_q_empty", sv_q.size(), 0);
    chk("t2_done_lat", done_a_cyc - last_hs_cyc, 1);

    // Both requests high: save wins, restore pulses ignored.
    for (int n = 0; n < 32; n++) rf_a[n] = 32'h7700 + n;
    chk_consec = 1'b1;
    start_save(1'b1);
    d0 = done_a_cnt;
    k = 0;
    while (done_a_cnt == d0 && k < 400) begin
      restore_req_a = (k % 2 == 0);
      tick();
      k++;
    end
    restore_req_a = 1'b0;
    tick();
    chk("t4_done", done_a_cnt - d0, 1);
    chk("t4_beats", sv_beats - sv_beats0, 31);
    chk("t4_no_restore", stray_a, 0);

    // Restore 16 words on RV32E with valid gaps.
    w0 = wr_b_cnt;
    d0 = done_b_cnt;
    restore_req_b = 1'b1;
    tick();
    restore_req_b = 1'b0;
    for (int i = 0; i < 16; i++) begin
      if (i % 3 == 1) tick();
      restore_word(i, 32'hA0 + i);
    end
    for (int i = 0; i < 50 && done_b_cnt == d0; i++) tick();
    tick();
    chk("t3_writes", wr_b_cnt - w0, 16);
    chk("t3_wq_empty", wr_q.size(), 0);
    chk("t3_done", done_b_cnt - d0, 1);
    chk("t3_done_lat", done_b_cyc - last_we_b_cyc, 1);
    chk("t3_rf0", rf_b[0], 32'hA0);
    chk("t3_rf15", rf_b[15], 32'hAF);
    chk("t3_busy_after", busy_b, 0);

    // Abort after the 5th restore accept.
    w0 = wr_b_cnt;
    d0 = done_b_cnt;
    restore_req_b = 1'b1;
    tick();
    restore_req_b = 1'b0;
    for (int i = 0; i < 5; i++) restore_word(i, 32'hC0 + i);
    abort_b = 1'b1;
    tick();
    abort_b = 1'b0;
    chk("t5_aborted", aborted_b, 1);
    chk("t5_busy", busy_b, 0);
    chk("t5_rs_ready", bus_b.rs_ready_o, 0);
    chk("t5_we", bus_b.rf_we_o, 0);
    tick();
    chk("t5_aborted_pulse", aborted_b, 0);
    tick();
    chk("t5_writes", wr_b_cnt - w0, 5);
    chk("t5_no_done", done_b_cnt - d0, 0);
    chk("t5_rf4", rf_b[4], 32'hC4);
    chk("t5_rf5", rf_b[5], 32'hA5);

    // Abort in IDLE is ignored.
    abort_a = 1'b1;
    tick();
    abort_a = 1'b0;
    chk("idle_abort_pulse", aborted_a, 0);
    chk("idle_abort_busy", busy_a, 0);

    // Reset in the middle of a save.
    d0 = done_a_cnt;
    start_save(1'b0);
    tick(); tick(); tick();
    rst_i = 1'b1;
    tick();
    chk("mid_rst_busy", busy_a, 0);
    chk("mid_rst_valid", bus_a.sv_valid_o, 0);
    chk("mid_rst_done", done_a, 0);
    rst_i = 1'b0;
    sv_q.delete();
    tick();
    chk("mid_rst_no_done", done_a_cnt - d0, 0);

    // Checksum over xN = N.
    for (int n = 0; n < 32; n++) rf_a[n] = n;
    start_save(1'b0);
    wait_done_a();
`ifdef IBEX_RF_CTX_CHECKSUM_EN
    chk("csum_save", csum_a, 32'h1F0);
`else
    chk("csum_off", csum_a, 0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1);
  end

endmodule
